// File: rtl/ahb_burst_cmd.sv
// AHB burst to AXI AW/AR command converter. Undefined-length INCR bursts are counted
// beat by beat and split into MAX_INCR_LEN-beat commands.
module ahb_burst_cmd #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned ID_WIDTH     = 4,
   parameter int unsigned CMD_ID       = 0,
   parameter int unsigned MAX_INCR_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [2:0]            HBURST,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic [1:0]            AWBURST,
   output logic [ID_WIDTH-1:0]   AWID,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [7:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic [1:0]            ARBURST,
   output logic [ID_WIDTH-1:0]   ARID
);

   localparam logic [1:0] TrIdle   = 2'b00;
   localparam logic [1:0] TrNonseq = 2'b10;
   localparam logic [1:0] TrSeq    = 2'b11;

   localparam logic [1:0] AxiFixed = 2'b00;
   localparam logic [1:0] AxiIncr  = 2'b01;
   localparam logic [1:0] AxiWrap  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ISSUE} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
   logic [2:0]              cmd_size_q, cmd_size_d;
   logic                    cmd_write_q, cmd_write_d;
   logic [7:0]              cmd_len_q, cmd_len_d;
   logic [1:0]              cmd_burst_q, cmd_burst_d;
   logic [8:0]              beat_cnt_q, beat_cnt_d;
   logic                    cont_q, cont_d;

   logic is_term;
   logic at_cap;
   logic handshake;
   logic hready_out;
   logic aw_valid;
   logic ar_valid;

   // IDLE/NONSEQ end an undefined INCR; a SEQ at the cap is stalled and starts a continuation.
   assign is_term   = (HTRANS == TrIdle) || (HTRANS == TrNonseq);
   assign at_cap    = (HTRANS == TrSeq) && (beat_cnt_q == 9'(MAX_INCR_LEN));
   assign handshake = (state_q == S_ISSUE) && (cmd_write_q ? AWREADY : ARREADY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_addr_q  <= '0;
         cmd_size_q  <= '0;
         cmd_write_q <= 1'b0;
         cmd_len_q   <= '0;
         cmd_burst_q <= '0;
         beat_cnt_q  <= '0;
         cont_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_size_q  <= cmd_size_d;
         cmd_write_q <= cmd_write_d;
         cmd_len_q   <= cmd_len_d;
         cmd_burst_q <= cmd_burst_d;
         beat_cnt_q  <= beat_cnt_d;
         cont_q      <= cont_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_size_d  = cmd_size_q;
      cmd_write_d = cmd_write_q;
      cmd_len_d   = cmd_len_q;
      cmd_burst_d = cmd_burst_q;
      beat_cnt_d  = beat_cnt_q;
      cont_d      = cont_q;
      unique case (state_q)
         S_IDLE: begin
            if (HREADY && (HTRANS == TrNonseq)) begin
               cmd_addr_d  = HADDR;
               cmd_size_d  = HSIZE;
               cmd_write_d = HWRITE;
               beat_cnt_d  = '0;
               cont_d      = 1'b0;
               cmd_len_d   = '0;
               state_d     = S_ISSUE;
               if (HBURST == 3'b000) begin
                  cmd_burst_d = AxiFixed;
               end else if (HBURST == 3'b001) begin
                  cmd_burst_d = AxiIncr;
                  beat_cnt_d  = 9'd1;
                  state_d     = S_COUNT;
               end else begin
                  // Odd encodings are INCRx, even ones WRAPx; HBURST[2:1] selects 4/8/16.
                  cmd_burst_d = HBURST[0] ? AxiIncr : AxiWrap;
                  case (HBURST[2:1])
                     2'b01:   cmd_len_d = 8'd3;
                     2'b10:   cmd_len_d = 8'd7;
                     default: cmd_len_d = 8'd15;
                  endcase
               end
            end
         end
         S_COUNT: begin
            if (is_term || at_cap) begin
               cont_d = at_cap;
               if (beat_cnt_q == 9'd0) begin
                  state_d = S_IDLE;
               end else begin
                  cmd_len_d = 8'(beat_cnt_q - 9'd1);
                  state_d   = S_ISSUE;
               end
            end else if (HREADY && (HTRANS == TrSeq)) begin
               beat_cnt_d = beat_cnt_q + 9'd1;
            end
         end
         S_ISSUE: begin
            if (handshake) begin
               if (cont_q) begin
                  cmd_addr_d = cmd_addr_q + (ADDR_WIDTH'(MAX_INCR_LEN) << cmd_size_q);
                  beat_cnt_d = '0;
                  state_d    = S_COUNT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hready_out = 1'b1;
      aw_valid   = 1'b0;
      ar_valid   = 1'b0;
      unique case (state_q)
         S_IDLE:  hready_out = 1'b1;
         S_COUNT: hready_out = !(is_term || at_cap);
         S_ISSUE: begin
            hready_out = 1'b0;
            aw_valid   = cmd_write_q;
            ar_valid   = !cmd_write_q;
         end
         default: hready_out = 1'b1;
      endcase
   end

   assign HREADYOUT = hready_out;
   assign AWVALID   = aw_valid;
   assign ARVALID   = ar_valid;
   assign AWADDR    = cmd_addr_q;
   assign ARADDR    = cmd_addr_q;
   assign AWLEN     = cmd_len_q;
   assign ARLEN     = cmd_len_q;
   assign AWSIZE    = cmd_size_q;
   assign ARSIZE    = cmd_size_q;
   assign AWBURST   = cmd_burst_q;
   assign ARBURST   = cmd_burst_q;
   assign AWID      = ID_WIDTH'(CMD_ID);
   assign ARID      = ID_WIDTH'(CMD_ID);

endmodule

// File: tb/tb_ahb_burst_cmd.sv
// Directed bench for ahb_burst_cmd: fixed bursts, INCR counting and splitting, stalls, reset.
module tb_ahb_burst_cmd;

   logic        clk;
   logic        rst;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HREADY;
   logic        HREADYOUT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic [3:0]  AWID;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [3:0]  ARID;

   int n_tests = 0;
   int n_fail  = 0;

   ahb_burst_cmd #(
      .ADDR_WIDTH  (32),
      .ID_WIDTH    (4),
      .CMD_ID      (0),
      .MAX_INCR_LEN(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .HADDR    (HADDR),
      .HBURST   (HBURST),
      .HSIZE    (HSIZE),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HREADY   (HREADY),
      .HREADYOUT(HREADYOUT),
      .AWVALID  (AWVALID),
      .AWREADY  (AWREADY),
      .AWADDR   (AWADDR),
      .AWLEN    (AWLEN),
      .AWSIZE   (AWSIZE),
      .AWBURST  (AWBURST),
      .AWID     (AWID),
      .ARVALID  (ARVALID),
      .ARREADY  (ARREADY),
      .ARADDR   (ARADDR),
      .ARLEN    (ARLEN),
      .ARSIZE   (ARSIZE),
      .ARBURST  (ARBURST),
      .ARID     (ARID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ahb(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                      input logic wr, input logic [31:0] ad);
      HTRANS = tr;
      HBURST = bu;
      HSIZE  = sz;
      HWRITE = wr;
      HADDR  = ad;
   endtask

   initial begin
      rst = 1'b1; HREADY = 1'b1; AWREADY = 1'b0; ARREADY = 1'b0;
      ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0);
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("rst_hreadyout", HREADYOUT, 1);
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_arvalid", ARVALID, 0);
      chk("rst_awaddr", AWADDR, 0);
      chk("rst_awlen", AWLEN, 0);
      chk("rst_awid", AWID, 0);

      // WRAP8 write
      cyc(); ahb(2'b10, 3'b100, 3'd2, 1'b1, 32'h100); #1;
      chk("wrap8_idle_hro", HREADYOUT, 1);
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); AWREADY = 1'b1; #1;
      chk("wrap8_awvalid", AWVALID, 1);
      chk("wrap8_arvalid", ARVALID, 0);
      chk("wrap8_awaddr", AWADDR, 32'h100);
      chk("wrap8_awlen", AWLEN, 7);
      chk("wrap8_awsize", AWSIZE, 2);
      chk("wrap8_awburst", AWBURST, 2'b10);
      chk("wrap8_araddr", ARADDR, 32'h100);
      chk("wrap8_hro", HREADYOUT, 0);
      cyc(); AWREADY = 1'b0; #1;
      chk("wrap8_done_valid", AWVALID, 0);
      chk("wrap8_done_hro", HREADYOUT, 1);

      // INCR read: NONSEQ + 4 SEQ + IDLE
      cyc(); ahb(2'b10, 3'b001, 3'd2, 1'b0, 32'h40); #1;
      for (int i = 0; i < 4; i++) begin
         cyc(); ahb(2'b11, 3'b001, 3'd2, 1'b0, 32'h44 + 32'(4 * i)); #1;
         chk("incr_seq_hro", HREADYOUT, 1);
      end
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); #1;
      chk("incr_term_hro", HREADYOUT, 0);
      chk("incr_term_arvalid", ARVALID, 0);
      cyc(); #1;
      chk("incr_arvalid", ARVALID, 1);
      chk("incr_awvalid", AWVALID, 0);
      chk("incr_arlen", ARLEN, 4);
      chk("incr_araddr", ARADDR, 32'h40);
      chk("incr_arburst", ARBURST, 2'b01);
      chk("incr_hro_wait", HREADYOUT, 0);
      cyc(); ARREADY = 1'b1; #1;
      chk("incr_arvalid_held", ARVALID, 1);
      chk("incr_hro_held", HREADYOUT, 0);
      cyc(); ARREADY = 1'b0; #1;
      chk("incr_done_valid", ARVALID, 0);
      chk("incr_done_hro", HREADYOUT, 1);

      // INCR write of 20 beats, split 16 + 4
      cyc(); ahb(2'b10, 3'b001, 3'd2, 1'b1, 32'h0); #1;
      for (int i = 1; i < 16; i++) begin
         cyc(); ahb(2'b11, 3'b001, 3'd2, 1'b1, 32'(4 * i)); #1;
         chk("split_seq_hro", HREADYOUT, 1);
      end
      cyc(); ahb(2'b11, 3'b001, 3'd2, 1'b1, 32'h40); #1;
      chk("split_cap_hro", HREADYOUT, 0);
      chk("split_cap_valid", AWVALID, 0);
      cyc(); AWREADY = 1'b1; #1;
      chk("split1_awvalid", AWVALID, 1);
      chk("split1_awlen", AWLEN, 15);
      chk("split1_awaddr", AWADDR, 32'h0);
      chk("split1_hro", HREADYOUT, 0);
      cyc(); AWREADY = 1'b0; #1;
      chk("split_b17_hro", HREADYOUT, 1);
      chk("split_b17_valid", AWVALID, 0);
      chk("split_b17_addr", AWADDR, 32'h40);
      for (int i = 17; i < 20; i++) begin
         cyc(); ahb(2'b11, 3'b001, 3'd2, 1'b1, 32'(4 * i)); #1;
         chk("split_seq2_hro", HREADYOUT, 1);
      end
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); #1;
      chk("split_term_hro", HREADYOUT, 0);
      cyc(); AWREADY = 1'b1; #1;
      chk("split2_awvalid", AWVALID, 1);
      chk("split2_awlen", AWLEN, 3);
      chk("split2_awaddr", AWADDR, 32'h40);
      chk("split2_awburst", AWBURST, 2'b01);
      cyc(); AWREADY = 1'b0; #1;
      chk("split_done_valid", AWVALID, 0);
      chk("split_done_hro", HREADYOUT, 1);

      // SINGLE read with ARREADY low for 5 cycles
      cyc(); ahb(2'b10, 3'b000, 3'd1, 1'b0, 32'h80); #1;
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         ARREADY = 1'b0; #1;
         chk("single_arvalid", ARVALID, 1);
         chk("single_araddr", ARADDR, 32'h80);
         chk("single_arlen", ARLEN, 0);
         chk("single_arburst", ARBURST, 2'b00);
         chk("single_arsize", ARSIZE, 1);
         chk("single_hro", HREADYOUT, 0);
         cyc();
      end
      ARREADY = 1'b1; #1;
      chk("single_hs_valid", ARVALID, 1);
      cyc(); ARREADY = 1'b0; #1;
      chk("single_done_valid", ARVALID, 0);
      chk("single_done_hro", HREADYOUT, 1);

      // Reset during S_ISSUE
      cyc(); ahb(2'b10, 3'b011, 3'd3, 1'b1, 32'h200); #1;
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); #1;
      chk("incr4_awvalid", AWVALID, 1);
      chk("incr4_awlen", AWLEN, 3);
      chk("incr4_awburst", AWBURST, 2'b01);
      chk("incr4_awsize", AWSIZE, 3);
      rst = 1'b1;
      cyc(); rst = 1'b0; #1;
      chk("midrst_awvalid", AWVALID, 0);
      chk("midrst_arvalid", ARVALID, 0);
      chk("midrst_hro", HREADYOUT, 1);
      chk("midrst_awaddr", AWADDR, 0);
      chk("midrst_araddr", ARADDR, 0);
      chk("midrst_awlen", AWLEN, 0);
      chk("midrst_awsize", AWSIZE, 0);
      chk("midrst_awburst", AWBURST, 0);

      // INCR with BUSY, terminated by a NONSEQ SINGLE read
      cyc(); ahb(2'b10, 3'b001, 3'd0, 1'b1, 32'h300); #1;
      cyc(); ahb(2'b11, 3'b001, 3'd0, 1'b1, 32'h301); #1;
      cyc(); ahb(2'b01, 3'b001, 3'd0, 1'b1, 32'h302); #1;
      chk("busy_hro", HREADYOUT, 1);
      cyc(); #1;
      cyc(); ahb(2'b11, 3'b001, 3'd0, 1'b1, 32'h302); #1;
      cyc(); ahb(2'b10, 3'b000, 3'd2, 1'b0, 32'h400); #1;
      chk("busy_term_hro", HREADYOUT, 0);
      cyc(); AWREADY = 1'b1; #1;
      chk("busy_awvalid", AWVALID, 1);
      chk("busy_awlen", AWLEN, 2);
      chk("busy_awaddr", AWADDR, 32'h300);
      chk("busy_awsize", AWSIZE, 0);
      cyc(); AWREADY = 1'b0; #1;
      chk("busy_idle_hro", HREADYOUT, 1);
      chk("busy_idle_valid", AWVALID, 0);
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); ARREADY = 1'b1; #1;
      chk("resample_arvalid", ARVALID, 1);
      chk("resample_araddr", ARADDR, 32'h400);
      chk("resample_arlen", ARLEN, 0);
      chk("resample_arsize", ARSIZE, 2);
      cyc(); ARREADY = 1'b0; #1;
      chk("resample_done", ARVALID, 0);

      // Continuation that ends with zero beats issues nothing
      cyc(); ahb(2'b10, 3'b001, 3'd1, 1'b1, 32'h1000); #1;
      for (int i = 1; i < 17; i++) begin
         cyc(); ahb(2'b11, 3'b001, 3'd1, 1'b1, 32'h1000 + 32'(2 * i)); #1;
      end
      chk("zero_cap_hro", HREADYOUT, 0);
      cyc(); AWREADY = 1'b1; #1;
      chk("zero_first_len", AWLEN, 15);
      cyc(); AWREADY = 1'b0; ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); #1;
      chk("zero_cont_addr", AWADDR, 32'h1020);
      chk("zero_idle_hro", HREADYOUT, 0);
      cyc(); #1;
      chk("zero_no_valid", AWVALID, 0);
      chk("zero_back_idle_hro", HREADYOUT, 1);
      cyc(); #1;
      chk("zero_still_no_valid", AWVALID, 0);

      // SEQ in idle, READY without VALID, NONSEQ with HREADY low: all ignored
      cyc(); ahb(2'b11, 3'b001, 3'd2, 1'b1, 32'h500); AWREADY = 1'b1; ARREADY = 1'b1; #1;
      chk("idle_seq_hro", HREADYOUT, 1);
      cyc(); HREADY = 1'b0; ahb(2'b10, 3'b000, 3'd2, 1'b1, 32'h600); #1;
      chk("idle_seq_awvalid", AWVALID, 0);
      chk("idle_seq_arvalid", ARVALID, 0);
      cyc(); HREADY = 1'b1; AWREADY = 1'b0; ARREADY = 1'b0;
      ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); #1;
      chk("hready_low_awvalid", AWVALID, 0);

      // INCR16 read and WRAP4 write encodings
      cyc(); ahb(2'b10, 3'b111, 3'd2, 1'b0, 32'h700); #1;
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); ARREADY = 1'b1; #1;
      chk("incr16_arlen", ARLEN, 15);
      chk("incr16_arburst", ARBURST, 2'b01);
      cyc(); ARREADY = 1'b0; ahb(2'b10, 3'b010, 3'd1, 1'b1, 32'h804); #1;
      cyc(); ahb(2'b00, 3'b000, 3'd0, 1'b0, 32'h0); AWREADY = 1'b1; #1;
      chk("wrap4_awlen", AWLEN, 3);
      chk("wrap4_awburst", AWBURST, 2'b10);
      chk("wrap4_awaddr", AWADDR, 32'h804);
      cyc(); AWREADY = 1'b0; #1;
      chk("wrap4_done", AWVALID, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
